// File: rtl/viterbi_decode.sv
`default_nettype none
// ============================================================================
//  Module   : viterbi_decode
//  Purpose  : Hard-decision Viterbi decoder for the rate-1/2, K=3 (7,5 octal)
//             convolutional code. Re-pairs a serial bit stream into code
//             symbols, runs 4-state add-compare-select with register-exchange
//             survivors, and emits one decoded bit per symbol after a fixed
//             decision delay of TB_DEPTH-1 symbols.
//  Ports    : clk20M_sig       - system clock, rising edge
//             reset_sig        - asynchronous active-low reset
//             serial_in_sig    - encoded bit (G1 first, then G2)
//             serial_valid_sig - qualifies serial_in_sig
//             sync_sig         - with valid, marks the first bit of a pair
//             decode_sig       - decoded information bit
//             decode_valid_sig - one-cycle strobe qualifying decode_sig
//             err_cnt_sig      - accumulated best-path branch cost
//                                (present only with VITERBI_ERRCNT_EN)
//  Options  : define VITERBI_ERRCNT_EN to add the error counter port/logic.
//  Revision : 1.0 - initial release
// ============================================================================
module viterbi_decode #(
    parameter int TB_DEPTH = 16,
    parameter int METRIC_W = 6
) (
    input  logic        clk20M_sig,
    input  logic        reset_sig,
    input  logic        serial_in_sig,
    input  logic        serial_valid_sig,
    input  logic        sync_sig,
    output logic        decode_sig,
    output logic        decode_valid_sig
`ifdef VITERBI_ERRCNT_EN
    ,
    output logic [15:0] err_cnt_sig
`endif
);

    localparam int                  c_CAND_W     = METRIC_W + 1;
    localparam int                  c_FILL_W     = $clog2(TB_DEPTH + 1);
    localparam logic [METRIC_W-1:0] c_METRIC_MAX = {METRIC_W{1'b1}};
    localparam logic [c_FILL_W-1:0] c_FILL_FULL  = c_FILL_W'(TB_DEPTH);

    logic                r_phase;
    logic                r_held;
    logic [METRIC_W-1:0] r_metric [4];
    logic [TB_DEPTH-1:0] r_surv   [4];
    logic [c_FILL_W-1:0] r_fill;
    logic                r_emit_d;
    logic                r_decode;
    logic                r_decode_valid;

    logic                w_fire;
    logic [1:0]          w_sym;
    logic [c_CAND_W-1:0] w_cand     [4];
    logic [c_CAND_W-1:0] w_min;
    logic [METRIC_W-1:0] w_norm     [4];
    logic [TB_DEPTH-1:0] w_new_surv [4];
    logic [c_FILL_W-1:0] w_fill_next;
    logic [1:0]          w_best_idx;
    logic [METRIC_W-1:0] w_best_val;

    // ------------------------------------------------------------------
    // Pair assembler: a sync-marked bit always restarts a pair, replacing
    // whatever first bit was being held.
    // ------------------------------------------------------------------
    assign w_fire = serial_valid_sig & ~sync_sig & r_phase;
    assign w_sym  = {r_held, serial_in_sig};

    always_ff @(posedge clk20M_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_phase <= 1'b0;
            r_held  <= 1'b0;
        end else if (serial_valid_sig) begin
            if (sync_sig || !r_phase) begin
                r_held  <= serial_in_sig;
                r_phase <= 1'b1;
            end else begin
                r_phase <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // ACS per next state {u,a}: predecessors are {a,0} and {a,1}. The
    // expected code pair from {a,1} is the bitwise inverse of that from
    // {a,0}, since b feeds both generators.
    // ------------------------------------------------------------------
    always_comb begin
        w_min = w_cand[0];
        for (int i = 1; i < 4; i++) begin
            if (w_cand[i] < w_min) begin
                w_min = w_cand[i];
            end
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_acs
        localparam logic       c_U    = ((gi >> 1) & 1) != 0;
        localparam logic       c_A    = (gi & 1) != 0;
        localparam int         c_P0   = 2 * (gi & 1);
        localparam int         c_P1   = c_P0 + 1;
        localparam logic [1:0] c_EXP0 = {c_U ^ c_A, c_U};
        localparam logic [1:0] c_EXP1 = c_EXP0 ^ 2'b11;

        logic [1:0]          w_d0;
        logic [1:0]          w_d1;
        logic [c_CAND_W-1:0] w_c0;
        logic [c_CAND_W-1:0] w_c1;
        logic [c_CAND_W-1:0] w_diff;
        logic                w_sel;

        assign w_d0  = w_sym ^ c_EXP0;
        assign w_d1  = w_sym ^ c_EXP1;
        assign w_c0  = {1'b0, r_metric[c_P0]} + c_CAND_W'(w_d0[1]) + c_CAND_W'(w_d0[0]);
        assign w_c1  = {1'b0, r_metric[c_P1]} + c_CAND_W'(w_d1[1]) + c_CAND_W'(w_d1[0]);
        // Strict compare: a tie keeps the b=0 predecessor.
        assign w_sel = (w_c1 < w_c0);

        assign w_cand[gi]     = w_sel ? w_c1 : w_c0;
        assign w_new_surv[gi] = {(w_sel ? r_surv[c_P1][TB_DEPTH-2:0]
                                        : r_surv[c_P0][TB_DEPTH-2:0]), c_U};

        assign w_diff         = w_cand[gi] - w_min;
        assign w_norm[gi]     = (w_diff > {1'b0, c_METRIC_MAX}) ? c_METRIC_MAX
                                                                : w_diff[METRIC_W-1:0];
    end

    assign w_fill_next = (r_fill == c_FILL_FULL) ? r_fill : r_fill + 1'b1;

    always_ff @(posedge clk20M_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            for (int i = 0; i < 4; i++) begin
                r_metric[i] <= (i == 0) ? '0 : c_METRIC_MAX;
                r_surv[i]   <= '0;
            end
            r_fill   <= '0;
            r_emit_d <= 1'b0;
        end else begin
            r_emit_d <= w_fire && (w_fill_next == c_FILL_FULL);
            if (w_fire) begin
                for (int i = 0; i < 4; i++) begin
                    r_metric[i] <= w_norm[i];
                    r_surv[i]   <= w_new_surv[i];
                end
                r_fill <= w_fill_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Decision stage, one cycle after the ACS update: pick the lowest-index
    // state holding the smallest stored metric and emit its oldest bit. No
    // symbol can fire on this cycle, so the stored survivors are stable.
    // ------------------------------------------------------------------
    always_comb begin
        w_best_idx = 2'd0;
        w_best_val = r_metric[0];
        for (int i = 1; i < 4; i++) begin
            if (r_metric[i] < w_best_val) begin
                w_best_val = r_metric[i];
                w_best_idx = 2'(i);
            end
        end
    end

    always_ff @(posedge clk20M_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_decode       <= 1'b0;
            r_decode_valid <= 1'b0;
        end else begin
            r_decode_valid <= r_emit_d;
            if (r_emit_d) begin
                r_decode <= r_surv[w_best_idx][TB_DEPTH-1];
            end
        end
    end

    assign decode_sig       = r_decode;
    assign decode_valid_sig = r_decode_valid;

`ifdef VITERBI_ERRCNT_EN
    // Stored metrics are normalised (best is 0), so the pre-normalisation
    // minimum is exactly the best path's cost for this symbol.
    logic [15:0] r_err_cnt;
    logic [16:0] w_err_sum;

    assign w_err_sum = {1'b0, r_err_cnt} + 17'(w_min);

    always_ff @(posedge clk20M_sig or negedge reset_sig) begin
        if (!reset_sig) begin
            r_err_cnt <= '0;
        end else if (w_fire) begin
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign err_cnt_sig = r_err_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_viterbi_decode.sv
`default_nettype none
// ============================================================================
//  Module   : tb_viterbi_decode
//  Purpose  : Self-checking bench for viterbi_decode. Streams are produced by
//             a behavioural (7,5) encoder; decoded strobes are collected and
//             compared against the information bits that were encoded.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_viterbi_decode;

    localparam int TB_DEPTH = 16;
    localparam int METRIC_W = 6;

    logic clk20M_sig       = 1'b0;
    logic reset_sig        = 1'b0;
    logic serial_in_sig    = 1'b0;
    logic serial_valid_sig = 1'b0;
    logic sync_sig         = 1'b0;
    logic decode_sig;
    logic decode_valid_sig;
`ifdef VITERBI_ERRCNT_EN
    logic [15:0] err_cnt_sig;
`endif

    viterbi_decode #(
        .TB_DEPTH (TB_DEPTH),
        .METRIC_W (METRIC_W)
    ) u_dut (
        .clk20M_sig       (clk20M_sig),
        .reset_sig        (reset_sig),
        .serial_in_sig    (serial_in_sig),
        .serial_valid_sig (serial_valid_sig),
        .sync_sig         (sync_sig),
        .decode_sig       (decode_sig),
        .decode_valid_sig (decode_valid_sig)
`ifdef VITERBI_ERRCNT_EN
        ,
        .err_cnt_sig      (err_cnt_sig)
`endif
    );

    always #25 clk20M_sig = ~clk20M_sig;

    int   n_tests = 0;
    int   n_fail  = 0;
    logic q_got   [$];
    logic tx_info [$];
    logic tx_bits [$];

    // Collect every decoded strobe while out of reset.
    always @(negedge clk20M_sig) begin
        if (reset_sig && decode_valid_sig) q_got.push_back(decode_sig);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk20M_sig);
    endtask

    task automatic drive_bit(input logic b, input logic s);
        serial_in_sig    = b;
        serial_valid_sig = 1'b1;
        sync_sig         = s;
        @(negedge clk20M_sig);
        serial_valid_sig = 1'b0;
        sync_sig         = 1'b0;
    endtask

    // Reference encoder: state {a,b}, g1 = u^a^b, g2 = u^b, starting in 00.
    task automatic encode_info();
        logic a, b, u;
        a = 1'b0;
        b = 1'b0;
        tx_bits.delete();
        foreach (tx_info[i]) begin
            u = tx_info[i];
            tx_bits.push_back(u ^ a ^ b);
            tx_bits.push_back(u ^ b);
            b = a;
            a = u;
        end
    endtask

    task automatic random_info(input int n);
        tx_info.delete();
        for (int i = 0; i < n; i++) tx_info.push_back(1'($urandom));
    endtask

    task automatic zero_tail();
        for (int i = 0; i < TB_DEPTH; i++) tx_info.push_back(1'b0);
    endtask

    task automatic send_bits(input int first, input int last, input int max_gap,
                             input logic first_sync);
        for (int i = first; i < last; i++) begin
            if (max_gap > 0) idle(int'($urandom_range(max_gap, 0)));
            drive_bit(tx_bits[i], first_sync && (i == first));
        end
    endtask

    // Expected output: one strobe per symbol from the TB_DEPTH-th on,
    // carrying the information bits in order from u[0].
    task automatic check_decoded(input string tag);
        int n_exp;
        n_exp = tx_info.size() - TB_DEPTH + 1;
        idle(4);
        chk({tag, "_count"}, q_got.size(), n_exp);
        for (int i = 0; i < n_exp && i < q_got.size(); i++) begin
            chk($sformatf("%s_bit%0d", tag, i), {31'd0, q_got[i]}, {31'd0, tx_info[i]});
        end
    endtask

    task automatic do_reset();
        reset_sig = 1'b0;
        repeat (4) begin
            serial_in_sig    = 1'($urandom);
            serial_valid_sig = 1'($urandom);
            sync_sig         = 1'($urandom);
            @(negedge clk20M_sig);
        end
        chk("rst_decode", {31'd0, decode_sig}, 32'd0);
        chk("rst_valid", {31'd0, decode_valid_sig}, 32'd0);
`ifdef VITERBI_ERRCNT_EN
        chk("rst_errcnt", {16'd0, err_cnt_sig}, 32'd0);
`endif
        serial_in_sig    = 1'b0;
        serial_valid_sig = 1'b0;
        sync_sig         = 1'b0;
        reset_sig        = 1'b1;
        q_got.delete();
        @(negedge clk20M_sig);
    endtask

    initial begin
        int flips;

        // Reset, then all-zero stream.
        do_reset();
        tx_info.delete();
        for (int i = 0; i < 40; i++) tx_info.push_back(1'b0);
        encode_info();
        send_bits(0, tx_bits.size(), 0, 1'b0);
        check_decoded("zero");
`ifdef VITERBI_ERRCNT_EN
        chk("zero_errcnt", {16'd0, err_cnt_sig}, 32'd0);
`endif

        // Known vector 1,0,1,1,0,0 plus zero tail.
        do_reset();
        tx_info = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        zero_tail();
        encode_info();
        send_bits(0, tx_bits.size(), 0, 1'b0);
        check_decoded("known");
`ifdef VITERBI_ERRCNT_EN
        chk("known_errcnt", {16'd0, err_cnt_sig}, 32'd0);
`endif

        // 200 random bits with bit 3 of every 16 serial bits flipped.
        do_reset();
        random_info(200);
        zero_tail();
        encode_info();
        flips = 0;
        for (int i = 3; i < 400; i += 16) begin
            tx_bits[i] = ~tx_bits[i];
            flips++;
        end
        send_bits(0, tx_bits.size(), 0, 1'b0);
        check_decoded("errors");
`ifdef VITERBI_ERRCNT_EN
        chk("errors_errcnt", {16'd0, err_cnt_sig}, flips);
`endif

        // Random valid gaps.
        do_reset();
        random_info(30);
        zero_tail();
        encode_info();
        send_bits(0, tx_bits.size(), 3, 1'b0);
        check_decoded("gaps");

        // One stray bit leaves a half pair; sync on the real first bit realigns.
        do_reset();
        random_info(30);
        zero_tail();
        encode_info();
        drive_bit(1'($urandom), 1'b0);
        send_bits(0, tx_bits.size(), 3, 1'b1);
        check_decoded("sync");

        // Mid-stream reset after 20 back-to-back symbols.
        do_reset();
        random_info(20);
        encode_info();
        send_bits(0, tx_bits.size(), 0, 1'b0);
        chk("mid_strobe_gap", {31'd0, decode_valid_sig}, 32'd0);
        @(negedge clk20M_sig);
        chk("mid_strobe_late", {31'd0, decode_valid_sig}, 32'd1);
        chk("mid_strobe_bit", {31'd0, decode_sig}, {31'd0, tx_info[20 - TB_DEPTH]});
        reset_sig = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, decode_valid_sig}, 32'd0);
        chk("mid_rst_decode", {31'd0, decode_sig}, 32'd0);
`ifdef VITERBI_ERRCNT_EN
        chk("mid_rst_errcnt", {16'd0, err_cnt_sig}, 32'd0);
`endif
        do_reset();
        random_info(24);
        zero_tail();
        encode_info();
        send_bits(0, 2 * (TB_DEPTH - 1), 0, 1'b0);
        idle(4);
        chk("mid_nofill", q_got.size(), 0);
        send_bits(2 * (TB_DEPTH - 1), tx_bits.size(), 1, 1'b0);
        check_decoded("mid_new");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
